ctrl_phase_decoder: RTL and testbench

Consumes the `state_count` / `end_signal` pair produced by the array controller's step counter. Turns each counter advance into registered, one-cycle phase strobes with row/column indices for the 128x128 systolic array: weight load, input feed, and output drain. It checks that the counter sequence is legal and reports job completion to the host through a valid/ready handshake. It sits between the controller counter and the array's weight, input and output buffers.

---
 rtl/ctrl_phase_decoder.sv | 145 ++++++++++++++
 tb/tb_ctrl_phase_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_phase_decoder.sv
// Decodes the controller's step counter into one-cycle weight/feed/drain strobes,
// checks the counter sequence for legality and reports job completion via valid/ready.
module ctrl_phase_decoder #(
  parameter int N  = 128,
  parameter int CW = 9,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CW-1:0] state_count,
  input  logic          end_signal,
  input  logic          done_ready,
  output logic          weight_load_en,
  output logic [IW-1:0] weight_row,
  output logic          feed_en,
  output logic [IW-1:0] feed_idx,
  output logic          drain_en,
  output logic [IW-1:0] drain_col,
  output logic          done_valid,
  output logic          seq_err,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4,
    HALT  = 3'd5
  } state_t;

  localparam logic [CW-1:0] S_ZERO = '0;
  localparam logic [CW-1:0] S_ONE  = CW'(1);
  localparam logic [CW-1:0] S_N    = CW'(N);
  localparam logic [CW-1:0] S_2N   = CW'(2 * N);
  localparam logic [CW-1:0] S_LAST = CW'(3 * N - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] prev_count_reg;
  logic          end_d_reg;
  logic          weight_load_en_reg, feed_en_reg, drain_en_reg;
  logic [IW-1:0] weight_row_reg, feed_idx_reg, drain_col_reg;
  logic          done_valid_reg, seq_err_reg;

  logic w_next, f_next, d_next, err_set, done_set;
  logic adv, step_adv, terminal, end_rise;

  // s = prev_count_reg is the step that just completed
  assign adv      = (state_count != prev_count_reg);
  assign step_adv = adv && (state_count == CW'(prev_count_reg + S_ONE)) && !end_signal;
  assign terminal = adv && (prev_count_reg == S_LAST) && (state_count == S_ONE)
                    && end_signal && !end_d_reg;
  assign end_rise = end_signal && !end_d_reg;

  always_comb begin
    state_next = state_reg;
    w_next     = 1'b0;
    f_next     = 1'b0;
    d_next     = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    if (state_reg != HALT) begin
      if (end_rise && !terminal) err_set = 1'b1;
      if (adv) begin
        unique case (state_reg)
          IDLE: begin
            if (step_adv && prev_count_reg == S_ZERO) begin
              state_next = LOAD;
              w_next     = 1'b1;
            end else err_set = 1'b1;
          end
          LOAD: begin
            if (step_adv && prev_count_reg > S_ZERO && prev_count_reg < S_N) begin
              w_next = 1'b1;
            end else if (step_adv && prev_count_reg == S_N) begin
              state_next = FEED;
              f_next     = 1'b1;
            end else err_set = 1'b1;
          end
          FEED: begin
            if (step_adv && prev_count_reg > S_N && prev_count_reg < S_2N) begin
              f_next = 1'b1;
            end else if (step_adv && prev_count_reg == S_2N) begin
              state_next = DRAIN;
              d_next     = 1'b1;
            end else err_set = 1'b1;
          end
          DRAIN: begin
            // the last drain step is only accepted as the terminal advance
            if (step_adv && prev_count_reg > S_2N && prev_count_reg < S_LAST) begin
              d_next = 1'b1;
            end else if (terminal) begin
              state_next = DONE;
              d_next     = 1'b1;
              done_set   = 1'b1;
            end else err_set = 1'b1;
          end
          default: err_set = 1'b1;
        endcase
      end
      if (state_reg == DONE && done_valid_reg && done_ready) state_next = HALT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg          <= IDLE;
      prev_count_reg     <= '0;
      end_d_reg          <= 1'b0;
      weight_load_en_reg <= 1'b0;
      feed_en_reg        <= 1'b0;
      drain_en_reg       <= 1'b0;
      weight_row_reg     <= '0;
      feed_idx_reg       <= '0;
      drain_col_reg      <= '0;
      done_valid_reg     <= 1'b0;
      seq_err_reg        <= 1'b0;
    end else begin
      state_reg          <= state_next;
      prev_count_reg     <= state_count;
      end_d_reg          <= end_signal;
      weight_load_en_reg <= w_next;
      feed_en_reg        <= f_next;
      drain_en_reg       <= d_next;
      if (w_next) weight_row_reg <= prev_count_reg[IW-1:0];
      if (f_next) feed_idx_reg   <= IW'(prev_count_reg - S_N);
      if (d_next) drain_col_reg  <= IW'(prev_count_reg - S_2N);
      if (err_set) seq_err_reg <= 1'b1;
      if (done_set) done_valid_reg <= 1'b1;
      else if (done_valid_reg && done_ready) done_valid_reg <= 1'b0;
    end
  end

  assign weight_load_en = weight_load_en_reg;
  assign weight_row     = weight_row_reg;
  assign feed_en        = feed_en_reg;
  assign feed_idx       = feed_idx_reg;
  assign drain_en       = drain_en_reg;
  assign drain_col      = drain_col_reg;
  assign done_valid     = done_valid_reg;
  assign seq_err        = seq_err_reg;
  assign phase          = state_reg;

endmodule

// File: tb/tb_ctrl_phase_decoder.sv
// Bench for ctrl_phase_decoder: emulates the step counter (with random stalls) and
// compares strobes, indices, phase and handshake against the job's step arithmetic.
module tb_ctrl_phase_decoder;
  localparam int N     = 128;
  localparam int CW    = 9;
  localparam int IW    = 7;
  localparam int STEPS = 3 * N;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_LOAD  = 3'd1;
  localparam logic [2:0] PH_FEED  = 3'd2;
  localparam logic [2:0] PH_DRAIN = 3'd3;
  localparam logic [2:0] PH_DONE  = 3'd4;
  localparam logic [2:0] PH_HALT  = 3'd5;

  logic          clk = 1'b0;
  logic          rstn;
  logic [CW-1:0] state_count;
  logic          end_signal;
  logic          done_ready;
  logic          weight_load_en, feed_en, drain_en;
  logic [IW-1:0] weight_row, feed_idx, drain_col;
  logic          done_valid, seq_err;
  logic [2:0]    phase;

  int vectors    = 0;
  int miscompares = 0;

  ctrl_phase_decoder #(.N(N), .CW(CW), .IW(IW)) dut (
    .clk(clk), .rstn(rstn), .state_count(state_count), .end_signal(end_signal),
    .done_ready(done_ready), .weight_load_en(weight_load_en), .weight_row(weight_row),
    .feed_en(feed_en), .feed_idx(feed_idx), .drain_en(drain_en), .drain_col(drain_col),
    .done_valid(done_valid), .seq_err(seq_err), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    state_count = '0;
    end_signal  = 1'b0;
    done_ready  = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Counter emulation: completes steps 0..last_s; step 3N-1 is the terminal advance.
  task automatic drive_job(input int last_s, input bit stalls, input bit ready_noise);
    int n;
    bit ew, ef, ed, edone;
    logic [IW-1:0] eidx, gidx;
    logic [2:0] eph;
    for (int s = 0; s <= last_s; s++) begin
      n = stalls ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < n; k++) begin
        if (ready_noise) done_ready = 1'($urandom_range(0, 1));
        tick();
        vectors++;
        if ({weight_load_en, feed_en, drain_en} !== 3'b000) begin
          miscompares++;
          $display("FAIL stall_strobe step=%0d got=%b exp=000", s, {weight_load_en, feed_en, drain_en});
        end
      end
      if (ready_noise) done_ready = 1'($urandom_range(0, 1));
      state_count = (s == STEPS - 1) ? CW'(1) : CW'(s + 1);
      end_signal  = (s == STEPS - 1);
      tick();
      ew    = (s < N);
      ef    = (s >= N) && (s < 2 * N);
      ed    = (s >= 2 * N);
      eidx  = IW'(s % N);
      edone = (s == STEPS - 1);
      eph   = (s < N) ? PH_LOAD : (s < 2 * N) ? PH_FEED : (s < STEPS - 1) ? PH_DRAIN : PH_DONE;
      gidx  = ew ? weight_row : ef ? feed_idx : drain_col;
      vectors++;
      if ({weight_load_en, feed_en, drain_en} !== {ew, ef, ed}) begin
        miscompares++;
        $display("FAIL strobe step=%0d got=%b exp=%b", s, {weight_load_en, feed_en, drain_en}, {ew, ef, ed});
      end
      vectors++;
      if (gidx !== eidx) begin
        miscompares++;
        $display("FAIL index step=%0d got=%0d exp=%0d", s, gidx, eidx);
      end
      vectors++;
      if (done_valid !== edone) begin
        miscompares++;
        $display("FAIL done_valid step=%0d got=%b exp=%b", s, done_valid, edone);
      end
      vectors++;
      if (seq_err !== 1'b0 || phase !== eph) begin
        miscompares++;
        $display("FAIL err_phase step=%0d got=%b/%0d exp=0/%0d", s, seq_err, phase, eph);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({weight_load_en, feed_en, drain_en, done_valid, seq_err} !== 5'b0 ||
        weight_row !== '0 || feed_idx !== '0 || drain_col !== '0 || phase !== PH_IDLE) begin
      miscompares++;
      $display("FAIL reset_state got=%b%b%b%b%b idx=%0d/%0d/%0d ph=%0d exp=all0 ph=0",
               weight_load_en, feed_en, drain_en, done_valid, seq_err, weight_row, feed_idx, drain_col, phase);
    end
  endtask

  task automatic test_done_handshake(input int hold);
    done_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if (done_valid !== 1'b1 || phase !== PH_DONE || drain_en !== 1'b0) begin
        miscompares++;
        $display("FAIL done_hold cyc=%0d got=%b/%0d/%b exp=1/%0d/0", i, done_valid, phase, drain_en, PH_DONE);
      end
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    vectors++;
    if (done_valid !== 1'b0 || phase !== PH_HALT) begin
      miscompares++;
      $display("FAIL done_accept got=%b/%0d exp=0/%0d", done_valid, phase, PH_HALT);
    end
    for (int i = 0; i < 20; i++) begin
      state_count = CW'($urandom);
      tick();
      vectors++;
      if ({weight_load_en, feed_en, drain_en, done_valid, seq_err} !== 5'b0 || phase !== PH_HALT) begin
        miscompares++;
        $display("FAIL halt_quiet cyc=%0d got=%b ph=%0d exp=00000 ph=%0d",
                 i, {weight_load_en, feed_en, drain_en, done_valid, seq_err}, phase, PH_HALT);
      end
    end
  endtask

  task automatic test_full_job();
    do_reset();
    drive_job(STEPS - 1, 1'b0, 1'b0);
    test_done_handshake(10);
  endtask

  task automatic test_stalls();
    do_reset();
    drive_job(STEPS - 1, 1'b1, 1'b1);
    test_done_handshake(int'($urandom_range(0, 15)));
  endtask

  task automatic test_illegal_jump(input int j);
    do_reset();
    drive_job(j - 1, 1'b0, 1'b0);
    state_count = CW'(j + 2);
    tick();
    vectors++;
    if ({weight_load_en, feed_en, drain_en} !== 3'b000 || seq_err !== 1'b1 || phase !== PH_LOAD) begin
      miscompares++;
      $display("FAIL jump_detect from=%0d got=%b err=%b ph=%0d exp=000 err=1 ph=%0d",
               j, {weight_load_en, feed_en, drain_en}, seq_err, phase, PH_LOAD);
    end
    state_count = CW'(j + 3);
    tick();
    vectors++;
    if (weight_load_en !== 1'b1 || weight_row !== IW'(j + 2) || seq_err !== 1'b1) begin
      miscompares++;
      $display("FAIL jump_resume got=%b row=%0d err=%b exp=1 row=%0d err=1",
               weight_load_en, weight_row, seq_err, j + 2);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (seq_err !== 1'b1 || weight_load_en !== 1'b0 || weight_row !== IW'(j + 2)) begin
        miscompares++;
        $display("FAIL jump_sticky cyc=%0d got=%b/%b/%0d exp=1/0/%0d", i, seq_err, weight_load_en, weight_row, j + 2);
      end
    end
  endtask

  task automatic test_early_end();
    do_reset();
    drive_job(199, 1'b1, 1'b0);
    end_signal = 1'b1;
    tick();
    vectors++;
    if (seq_err !== 1'b1 || {weight_load_en, feed_en, drain_en} !== 3'b000 || done_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_end got=err%b str%b dv%b exp=err1 str000 dv0",
               seq_err, {weight_load_en, feed_en, drain_en}, done_valid);
    end
    for (int i = 0; i < 10; i++) begin
      state_count = CW'(201 + i);
      tick();
      vectors++;
      if (done_valid !== 1'b0 || seq_err !== 1'b1 || feed_en !== 1'b0 || phase !== PH_FEED) begin
        miscompares++;
        $display("FAIL early_end_after cyc=%0d got=dv%b err%b f%b ph%0d exp=dv0 err1 f0 ph%0d",
                 i, done_valid, seq_err, feed_en, phase, PH_FEED);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    drive_job(150, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rstn        = 1'b0;
    state_count = '0;
    end_signal  = 1'b0;
    #1;
    vectors++;
    if ({weight_load_en, feed_en, drain_en, done_valid, seq_err} !== 5'b0 ||
        weight_row !== '0 || feed_idx !== '0 || drain_col !== '0 || phase !== PH_IDLE) begin
      miscompares++;
      $display("FAIL mid_reset got=%b idx=%0d/%0d/%0d ph=%0d exp=00000 idx=0/0/0 ph=0",
               {weight_load_en, feed_en, drain_en, done_valid, seq_err}, weight_row, feed_idx, drain_col, phase);
    end
    tick();
    rstn = 1'b1;
    drive_job(STEPS - 1, 1'b0, 1'b0);
    test_done_handshake(int'($urandom_range(0, 5)));
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_stalls();
    test_illegal_jump(5);
    test_illegal_jump(int'($urandom_range(3, 100)));
    test_early_end();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
